// File: rtl/swap_pair_serializer_pkg.sv
// Shared defaults and serializer state encoding for swap_pair_serializer.
package swap_pair_serializer_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_FIRST  = 2'd1,
    ST_SEND_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/swap_pair_serializer_pair_fifo.sv
// Synchronous pair FIFO: DW-wide, DEPTH-deep, registered occupancy count.
module pair_fifo #(
  parameter  int unsigned DW    = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_c,
  output logic [LW-1:0] level_o,
  output logic          full_c,
  output logic          empty_c
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_c  = (cnt_q == LW'(DEPTH));
  assign empty_c = (cnt_q == LW'(0));
  assign push_ok = push_i && !full_c;
  assign pop_ok  = pop_i && !empty_c;
  assign head_c  = mem_q[rptr_q];
  assign level_o = cnt_q;

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  // Pointers and count; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/swap_pair_serializer.sv
// Buffers swapped byte pairs and emits them un-swapped as a byte stream (pair_b, then pair_a).
module swap_pair_serializer
  import swap_pair_serializer_pkg::*;
#(
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  pair_a,
  input  logic [W-1:0]  pair_b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level
);

  state_e         state_q;
  logic [W-1:0]   hold_a_q;
  logic [2*W-1:0] head_c;
  logic           full_c, empty_c;
  logic           push_c, pop_c;

  // Acceptance depends only on the registered count, never on out_ready.
  assign in_ready = !full_c;
  assign push_c   = in_valid && in_ready;

  pair_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .wdata_i ({pair_a, pair_b}),
    .pop_i   (pop_c),
    .head_c  (head_c),
    .level_o (level),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Pop when idle, or when the second byte of the current pair is accepted.
  always_comb begin
    pop_c = 1'b0;
    unique case (state_q)
      ST_IDLE:        pop_c = !empty_c;
      ST_SEND_SECOND: pop_c = out_ready && !empty_c;
      default:        pop_c = 1'b0;
    endcase
  end

  // Serializer FSM with registered byte outputs; holds everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_a_q  <= '0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty_c) begin
            hold_a_q  <= head_c[2*W-1:W];
            out_data  <= head_c[W-1:0];
            out_first <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= ST_SEND_FIRST;
          end
        end
        ST_SEND_FIRST: begin
          if (out_ready) begin
            out_data  <= hold_a_q;
            out_first <= 1'b0;
            state_q   <= ST_SEND_SECOND;
          end
        end
        ST_SEND_SECOND: begin
          if (out_ready) begin
            if (!empty_c) begin
              hold_a_q  <= head_c[2*W-1:W];
              out_data  <= head_c[W-1:0];
              out_first <= 1'b1;
              state_q   <= ST_SEND_FIRST;
            end else begin
              out_valid <= 1'b0;
              out_first <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_first <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/swap_pair_serializer.md
Name: swap_pair_serializer

Overview:
- Transmit-side counterpart to the team's registered byte-pair swap stage.
- Accepts swapped parallel pairs (pair_a = original second byte, pair_b = original first byte) through a valid/ready handshake and buffers them in a small pair FIFO.
- Un-swaps each pair and emits it as a serial byte stream in original order: pair_b first, then pair_a.
- Sits between the swap stage and any byte-wide downstream consumer (UART/SPI TX, byte bus).

Parameters:
- W, 8, byte width of pair_a, pair_b and out_data.
- DEPTH, 4, pair FIFO depth in pairs. Must be a power of 2 and at least 2.
- LW, $clog2(DEPTH)+1, width of the level output. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pair_a  in  W  swapped byte a (original second byte)
- pair_b  in  W  swapped byte b (original first byte)
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept a pair
- out_data  out  W  serial byte
- out_first  out  1  high while out_data holds the first byte of a pair
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- level  out  LW  pairs currently held in the FIFO (excludes the pair in the serializer)

Behaviour:
Clock and reset:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset, including mid-operation, immediately clears FIFO pointers, level, FSM and output register.
- Reset values: out_valid=0, out_first=0, out_data=0, level=0, FSM=IDLE. in_ready=1 as soon as rst_n is high.
- Any pair in flight during reset is discarded; no partial byte is emitted after reset releases.

Input side:
- Push occurs when in_valid && in_ready at a rising edge; {pair_a, pair_b} is written at wptr.
- in_ready = (level != DEPTH), decoded from registered count. No combinational path from out_ready.
- When full, in_ready=0 even if a pop happens in the same cycle (no full-bypass).
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Serializer FSM (IDLE, SEND_FIRST, SEND_SECOND):
- IDLE: if level>0, pop the head pair into a holding register, drive out_data=pair_b, out_first=1, out_valid=1, go to SEND_FIRST.
- SEND_FIRST: hold outputs while !out_ready. On out_ready, drive out_data=pair_a, out_first=0, go to SEND_SECOND.
- SEND_SECOND: hold while !out_ready. On out_ready:
  - if level>0, pop the next pair at the same edge, load its pair_b with out_first=1, go to SEND_FIRST;
  - otherwise out_valid=0, go to IDLE.
- out_data, out_first and out_valid are registered, stable, and never change while out_valid && !out_ready.

Timing:
- Latency: pair pushed at edge N into an empty block gives out_valid=1 with the first byte after edge N+1.
- Sustained throughput is 1 byte/cycle with out_ready held high, so 1 pair per 2 cycles. No bubble between pairs.
- level counts FIFO contents only; a popped pair no longer counts.

Decomposition:
- Shared package: W default, DEPTH default, FSM state encoding constants (IDLE=2'd0, SEND_FIRST=2'd1, SEND_SECOND=2'd2).
- One sub-module: pair_fifo (2W-wide, DEPTH-deep synchronous FIFO with push/pop/level/full/empty and async active-low reset). The serializer FSM stays in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 pairs queued -> out_valid=0, level=0, in_ready=1 immediately; no byte emitted after release until a new push.
- Single pair: push pair_a=8'hA5, pair_b=8'h3C, out_ready=1 -> edge N+1 out_data=3C/out_first=1, edge N+2 out_data=A5/out_first=0, edge N+3 out_valid=0.
- Back-to-back: push 4 pairs (a,b)=(01,10),(02,20),(03,30),(04,40), out_ready=1 -> byte stream 10,01,20,02,30,03,40,04 with no gaps; out_first high on 10,20,30,40.
- Backpressure/full: out_ready=0, push 6 pairs with DEPTH=4 -> serializer holds pair 1, FIFO holds 4, level=4, in_ready=0, pair 6 refused. out_data stays stable while stalled.
- Simultaneous push/pop at full: release out_ready while in_valid high -> level stays 4 until a pop frees space; no overwrite. Order is preserved across pointer wrap after 10+ pairs.
- Random stall: random in_valid/out_ready over 1000 pairs -> scoreboard of un-swapped bytes matches exactly; level never exceeds DEPTH.
